// File: rtl/dsd_pkg.sv
// Shared definitions for the serial datapath blocks: FSM state type and
// a counter-sizing helper.
package dsd_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Ceiling log2; returns 0 for v <= 1 so callers add their own headroom bit.
   function automatic int unsigned clog2_safe(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/subtractor_slice.sv
// Combinational ripple of SLICE full subtractors: d = x - y - bin, bout = final borrow.
module subtractor_slice #(
   parameter int unsigned SLICE = 1
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             bin,
   output logic [SLICE-1:0] d,
   output logic             bout
);

   logic [SLICE:0] c;

   always_comb begin
      c    = '0;
      d    = '0;
      c[0] = bin;
      for (int unsigned i = 0; i < SLICE; i++) begin
         d[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]);
      end
      bout = c[SLICE];
   end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, SLICE bits per cycle, LSB first,
// with start/busy/done handshake, unsigned borrow and signed overflow reporting.
module serial_subtractor
   import dsd_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SLICE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int unsigned N  = WIDTH / SLICE;
   localparam int unsigned CW = clog2_safe(N) + 1;

   if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of SLICE");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             done_q, done_d;
   logic             borrow_out_q, borrow_out_d;
   logic             ovf_q, ovf_d;

   logic [SLICE-1:0] sl_d;
   logic             sl_bout;
   logic             last;

   subtractor_slice #(.SLICE(SLICE)) u_slice (
      .x   (a_sh_q[SLICE-1:0]),
      .y   (b_sh_q[SLICE-1:0]),
      .bin (borrow_q),
      .d   (sl_d),
      .bout(sl_bout)
   );

   assign last = (count_q == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         res_q        <= '0;
         diff_q       <= '0;
         borrow_q     <= 1'b0;
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         done_q       <= 1'b0;
         borrow_out_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         res_q        <= res_d;
         diff_q       <= diff_d;
         borrow_q     <= borrow_d;
         a_msb_q      <= a_msb_d;
         b_msb_q      <= b_msb_d;
         done_q       <= done_d;
         borrow_out_q <= borrow_out_d;
         ovf_q        <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d      = count_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      res_d        = res_q;
      diff_d       = diff_q;
      borrow_d     = borrow_q;
      a_msb_d      = a_msb_q;
      b_msb_d      = b_msb_q;
      done_d       = 1'b0;
      borrow_out_d = borrow_out_q;
      ovf_d        = ovf_q;
      if (state_q == S_IDLE && start) begin
         a_sh_d   = a;
         b_sh_d   = b;
         borrow_d = borrow_in;
         a_msb_d  = a[WIDTH-1];
         b_msb_d  = b[WIDTH-1];
         count_d  = '0;
      end else if (state_q == S_RUN) begin
         // Operand MSBs are kept aside because the shift registers drain them.
         a_sh_d   = a_sh_q >> SLICE;
         b_sh_d   = b_sh_q >> SLICE;
         res_d    = (res_q >> SLICE) | (WIDTH'(sl_d) << (WIDTH - SLICE));
         borrow_d = sl_bout;
         count_d  = count_q + CW'(1);
         if (last) begin
            diff_d       = res_d;
            borrow_out_d = sl_bout;
            ovf_d        = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
            done_d       = 1'b1;
         end
      end
   end

   always_comb begin
      busy       = (state_q == S_RUN);
      done       = done_q;
      diff       = diff_q;
      borrow_out = borrow_out_q;
      ovf        = ovf_q;
   end

endmodule
